lifo_stack: RTL and testbench

- Parameterised LIFO data stack for the Forth core (data/return stack), with the top-of-stack (TOS) held in a register and the remaining cells in a small RAM.
- Controlled through the ss_io bundle: op, vi, tos, s0, flattened here into ports.
- TOS and the next-on-stack (s0) are always visible combinationally, so the ALU can consume both without waiting a cycle.

---
 rtl/ss_pkg.sv | 15 +
 rtl/ss_io.sv | 33 +++
 rtl/ss_ram.sv | 24 ++
 rtl/lifo_stack.sv | 94 +++++++++
 tb/tb_lifo_stack.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ss_pkg.sv
// Shared types and defaults for the Forth data/return stack.
// Op codes are fixed by the core's instruction decode.
package ss_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    REPL = 2'd3
  } ss_op_t;

  localparam int SS_DEPTH = 16;
  localparam int SS_DSZ   = 32;

endpackage

// File: rtl/ss_io.sv
// Stack control bundle between the core sequencer and lifo_stack.
// push/pop helpers let a master drive one op per cycle.
interface ss_io
  import ss_pkg::*;
#(
  parameter int DEPTH = SS_DEPTH,
  parameter int DSZ   = SS_DSZ
);

  logic [1:0]     op;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] s0;

  modport slave (
    input  op,
    input  vi,
    output tos,
    output s0
  );

  task automatic push(input logic [DSZ-1:0] v);
    op = PUSH;
    vi = v;
  endtask

  // tos is combinational, so the popped value is valid before the edge
  function automatic logic [DSZ-1:0] pop();
    op = POP;
    return tos;
  endfunction

endinterface

// File: rtl/ss_ram.sv
// Stack cell store below TOS: synchronous write, asynchronous read.
// Separate read/write addresses; a single op never hits both on one cell.
module ss_ram #(
  parameter int WORDS = 15,
  parameter int DSZ   = 32,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [DSZ-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [DSZ-1:0] rdata
);

  logic [DSZ-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with TOS in a register and deeper cells in ss_ram.
// tos and s0 are visible combinationally for the ALU.
module lifo_stack
  import ss_pkg::*;
#(
  parameter int DEPTH = SS_DEPTH,
  parameter int DSZ   = SS_DSZ,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int SPW  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] s0,
  output logic [DW-1:0]  depth,
  output logic           empty,
  output logic           full,
  output logic           ovf,
  output logic           udf
);

  ss_op_t         cmd;
  logic [SPW-1:0] sp;
  logic [SPW-1:0] raddr;
  logic [DSZ-1:0] rdata;
  logic           do_push;
  logic           do_pop;
  logic           do_repl;
  logic           deep;

  always_comb begin
    cmd = en ? ss_op_t'(op) : NOP;
  end

  assign empty = (depth == '0);
  assign full  = (depth == DW'(DEPTH));
  assign deep  = (depth >= DW'(2));

  // REPL on an empty stack is a push
  assign do_push = ((cmd == PUSH) && !full)
                 || ((cmd == REPL) && empty);
  assign do_pop  = (cmd == POP) && !empty;
  assign do_repl = (cmd == REPL) && !empty;

  assign raddr = (sp == '0) ? '0 : sp - SPW'(1);
  assign s0    = deep ? rdata : '0;

  ss_ram #(
    .WORDS (DEPTH - 1),
    .DSZ   (DSZ)
  ) u_ram (
    .clk   (clk),
    .we    (do_push && !empty),
    .waddr (sp),
    .wdata (tos),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      sp    <= '0;
      tos   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      ovf <= (cmd == PUSH) && full;
      udf <= (cmd == POP) && empty;
      unique case (1'b1)
        do_push: begin
          if (!empty) sp <= sp + SPW'(1);
          tos   <= vi;
          depth <= depth + DW'(1);
        end
        do_pop: begin
          if (deep) begin
            tos <= rdata;
            sp  <= sp - SPW'(1);
          end else begin
            tos <= '0;
          end
          depth <= depth - DW'(1);
        end
        do_repl: tos <= vi;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: a queue models the stack contents.
// Pops are checked against the queue tail before the clock edge.
module tb_lifo_stack;

  localparam int DEPTH = 16;
  localparam int DSZ   = 32;
  localparam int DW    = $clog2(DEPTH + 1);

  localparam logic [1:0] O_NOP  = 2'd0;
  localparam logic [1:0] O_PUSH = 2'd1;
  localparam logic [1:0] O_POP  = 2'd2;
  localparam logic [1:0] O_REPL = 2'd3;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [1:0]     op;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] s0;
  logic [DW-1:0]  depth;
  logic           empty;
  logic           full;
  logic           ovf;
  logic           udf;

  int checks   = 0;
  int failures = 0;

  logic [DSZ-1:0] sb[$];

  lifo_stack #(
    .DEPTH (DEPTH),
    .DSZ   (DSZ)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .op    (op),
    .vi    (vi),
    .tos   (tos),
    .s0    (s0),
    .depth (depth),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    logic [DSZ-1:0] etos;
    logic [DSZ-1:0] es0;
    n    = sb.size();
    etos = (n >= 1) ? sb[n-1] : '0;
    es0  = (n >= 2) ? sb[n-2] : '0;
    check({tag, ".tos"}, tos, etos);
    check({tag, ".s0"}, s0, es0);
    check({tag, ".depth"}, 32'(depth), n);
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
  endtask

  // One op per call: drive at negedge, sample 1ns after posedge
  task automatic step(input logic [1:0] o,
                      input logic [DSZ-1:0] v,
                      input logic e);
    int  n;
    logic eovf;
    logic eudf;
    n    = sb.size();
    eovf = e && (o == O_PUSH) && (n == DEPTH);
    eudf = e && (o == O_POP) && (n == 0);
    @(negedge clk);
    en = e;
    op = o;
    vi = v;
    if (e) begin
      case (o)
        O_PUSH: if (n < DEPTH) sb.push_back(v);
        O_POP: if (n > 0) begin
          #1 check("pop_val", tos, sb.pop_back());
        end
        O_REPL: if (n == 0) sb.push_back(v);
                else sb[n-1] = v;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    en = 1'b0;
    op = O_NOP;
    check("ovf", 32'(ovf), 32'(eovf));
    check("udf", 32'(udf), 32'(eudf));
    check_state("st");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    op  = O_NOP;
    vi  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    check("reset.ovf", 32'(ovf), 0);
    check("reset.udf", 32'(udf), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(O_PUSH, DSZ'(100 + i), 1'b1);
      step(O_PUSH, DSZ'(1000 + i), 1'b1);
      step(O_POP, '0, 1'b1);
      check("il.tos", tos, 100 + i);
      check("il.depth", 32'(depth), i + 1);
      if (i >= 1) check("il.s0", s0, 100 + i - 1);
    end
    check("il.final", 32'(depth), 15);

    for (int i = 0; i < 15; i++) begin
      step(O_POP, '0, 1'b1);
    end
    check("drain.empty", 32'(empty), 1);
    step(O_POP, '0, 1'b1);
    check("drain.udf", 32'(udf), 1);
    check("drain.tos", tos, 0);
    step(O_NOP, '0, 1'b1);
    check("drain.udf_clr", 32'(udf), 0);

    for (int i = 1; i <= 16; i++) begin
      step(O_PUSH, DSZ'(i), 1'b1);
    end
    check("ov.full", 32'(full), 1);
    check("ov.tos", tos, 16);
    check("ov.s0", s0, 15);
    step(O_PUSH, DSZ'(99), 1'b1);
    check("ov.ovf", 32'(ovf), 1);
    check("ov.tos_hold", tos, 16);
    check("ov.depth", 32'(depth), 16);
    step(O_NOP, '0, 1'b1);
    check("ov.ovf_clr", 32'(ovf), 0);
    for (int i = 0; i < 16; i++) begin
      step(O_POP, '0, 1'b1);
    end

    step(O_PUSH, DSZ'(5), 1'b0);
    check("en0.depth", 32'(depth), 0);
    step(O_PUSH, DSZ'(7), 1'b1);
    step(O_REPL, DSZ'(9), 1'b1);
    check("repl.tos", tos, 9);
    check("repl.depth", 32'(depth), 1);
    step(O_NOP, '0, 1'b1);
    check("nop.tos", tos, 9);

    for (int i = 0; i < 7; i++) begin
      step(O_PUSH, DSZ'($urandom), 1'b1);
    end
    check("mid.depth", 32'(depth), 8);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    check_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    step(O_PUSH, DSZ'(3), 1'b1);
    check("post.tos", tos, 3);
    check("post.depth", 32'(depth), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
